// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters (port 0: main execute
// path, port 1: auxiliary unit) with round-robin arbitration. One operation is
// in flight at a time: IDLE accepts a request and registers its operands, EXEC
// drives the ALU from those registers and captures its outputs, RESP holds the
// response until the owning requester takes it.
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   reqN_valid / reqN_ready       request handshake per port
//   reqN_op0, reqN_op1, reqN_ctrl operands and ALU control code per port
//   respN_valid / respN_ready     response handshake per port
//   resp_result, resp_result1     captured ALU results
//   resp_flags                    captured {overflow, sign, carry, zero}
//   resp_id                       port owning the current response
//   busy                          high whenever the FSM is not IDLE
//   alu_operand0/1, alu_control   registered drive to the ALU
//   alu_result, alu_result1, alu_*Flag   combinational ALU outputs
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_op0,
  input  logic [WIDTH-1:0]  req0_op1,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_op0,
  input  logic [WIDTH-1:0]  req1_op1,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [WIDTH-1:0]  resp_result,
  output logic [WIDTH-1:0]  resp_result1,
  output logic [3:0]        resp_flags,
  output logic              resp_id,
  output logic              busy,
  output logic [WIDTH-1:0]  alu_operand0,
  output logic [WIDTH-1:0]  alu_operand1,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [WIDTH-1:0]  alu_result1,
  input  logic              alu_zFlag,
  input  logic              alu_carryFlag,
  input  logic              alu_signFlag,
  input  logic              alu_overflowFlag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                resp_id_q, resp_id_d;
  logic [WIDTH-1:0]    op0_q, op0_d;
  logic [WIDTH-1:0]    op1_q, op1_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [WIDTH-1:0]    result1_q, result1_d;
  logic [3:0]          flags_q, flags_d;

  logic                grant0;
  logic                grant1;
  logic                resp_taken;

  // A lone valid always wins; on a tie the port that did not win last time
  // gets the grant. With no valid neither grant is raised, so both readies
  // stay low while the arbiter idles.
  assign grant0 = (state_q == IDLE) && req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = (state_q == IDLE) && req1_valid && (!req0_valid || !last_grant_q);

  // Only the owner's response ready can retire the response; the other port's
  // ready is deliberately ignored.
  assign resp_taken = resp_id_q ? resp1_ready : resp0_ready;

  // Next-state and datapath: operand registers change only on an accept, so
  // the ALU inputs stay frozen outside the accept edge.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    resp_id_d    = resp_id_q;
    op0_d        = op0_q;
    op1_d        = op1_q;
    ctrl_d       = ctrl_q;
    result_d     = result_q;
    result1_d    = result1_q;
    flags_d      = flags_q;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          op0_d        = req0_op0;
          op1_d        = req0_op1;
          ctrl_d       = req0_ctrl;
          resp_id_d    = 1'b0;
          last_grant_d = 1'b0;
          state_d      = EXEC;
        end else if (grant1) begin
          op0_d        = req1_op0;
          op1_d        = req1_op1;
          ctrl_d       = req1_ctrl;
          resp_id_d    = 1'b1;
          last_grant_d = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d  = alu_result;
        result1_d = alu_result1;
        flags_d   = {alu_overflowFlag, alu_signFlag, alu_carryFlag, alu_zFlag};
        state_d   = RESP;
      end
      RESP: begin
        if (resp_taken) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state in one register block; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      resp_id_q    <= 1'b0;
      op0_q        <= '0;
      op1_q        <= '0;
      ctrl_q       <= '0;
      result_q     <= '0;
      result1_q    <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      resp_id_q    <= resp_id_d;
      op0_q        <= op0_d;
      op1_q        <= op1_d;
      ctrl_q       <= ctrl_d;
      result_q     <= result_d;
      result1_q    <= result1_d;
      flags_q      <= flags_d;
    end
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign resp0_valid  = (state_q == RESP) && !resp_id_q;
  assign resp1_valid  = (state_q == RESP) &&  resp_id_q;
  assign busy         = (state_q != IDLE);
  assign resp_result  = result_q;
  assign resp_result1 = result1_q;
  assign resp_flags   = flags_q;
  assign resp_id      = resp_id_q;
  assign alu_operand0 = op0_q;
  assign alu_operand1 = op1_q;
  assign alu_control  = ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. A small behavioural ALU answers the DUT's
// ALU drive; expected responses come from the same model applied to the
// operands the bench issued, plus hand-computed constants for key vectors.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_op0, req0_op1, req1_op0, req1_op1;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp_result, resp_result1;
  logic [3:0]  resp_flags;
  logic        resp_id, busy;
  logic [31:0] alu_operand0, alu_operand1;
  logic [3:0]  alu_control;
  logic [31:0] alu_result, alu_result1;
  logic        alu_zFlag, alu_carryFlag, alu_signFlag, alu_overflowFlag;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op0(req0_op0), .req0_op1(req0_op1), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op0(req1_op0), .req1_op1(req1_op1), .req1_ctrl(req1_ctrl),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_result1(resp_result1),
    .resp_flags(resp_flags), .resp_id(resp_id), .busy(busy),
    .alu_operand0(alu_operand0), .alu_operand1(alu_operand1),
    .alu_control(alu_control),
    .alu_result(alu_result), .alu_result1(alu_result1),
    .alu_zFlag(alu_zFlag), .alu_carryFlag(alu_carryFlag),
    .alu_signFlag(alu_signFlag), .alu_overflowFlag(alu_overflowFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: result for each control code
  function automatic logic [31:0] m_res(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return {31'd0, ($signed(a) < $signed(b))};
      default: return a;
    endcase
  endfunction

  function automatic logic [31:0] m_res1(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    return (a ^ {b[15:0], b[31:16]}) + {28'd0, c};
  endfunction

  // Flags packed {overflow, sign, carry, zero}
  function automatic logic [3:0] m_flags(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    logic [31:0] r;
    logic [32:0] s;
    logic        z, cy, sg, ov;
    r  = m_res(a, b, c);
    s  = {1'b0, a} + {1'b0, b};
    z  = (r == 32'd0);
    sg = r[31];
    cy = 1'b0;
    ov = 1'b0;
    if (c == 4'd0) begin
      cy = s[32];
      ov = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (c == 4'd1) begin
      cy = (a < b);
      ov = (a[31] != b[31]) && (r[31] != a[31]);
    end
    return {ov, sg, cy, z};
  endfunction

  // The model ALU answers whatever the DUT drives
  always_comb begin
    logic [3:0] f;
    f                = m_flags(alu_operand0, alu_operand1, alu_control);
    alu_result       = m_res(alu_operand0, alu_operand1, alu_control);
    alu_result1      = m_res1(alu_operand0, alu_operand1, alu_control);
    alu_overflowFlag = f[3];
    alu_signFlag     = f[2];
    alu_carryFlag    = f[1];
    alu_zFlag        = f[0];
  end

  // One comparison: counts it, and reports tag/observed/expected on mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on port p; hold = extra RESP cycles with ready low.
  // During backpressure the other port requests and raises its response
  // ready, neither of which may disturb the transaction.
  task automatic applyStimulus(input bit p, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] c, input int hold);
    logic [31:0] er, er1;
    logic [3:0]  ef;
    er  = m_res(a, b, c);
    er1 = m_res1(a, b, c);
    ef  = m_flags(a, b, c);
    if (!p) begin
      req0_valid = 1'b1; req0_op0 = a; req0_op1 = b; req0_ctrl = c;
    end else begin
      req1_valid = 1'b1; req1_op0 = a; req1_op1 = b; req1_ctrl = c;
    end
    #1;
    checkOutput("idle_own_ready", p ? req1_ready : req0_ready, 32'd1);
    checkOutput("idle_other_ready", p ? req0_ready : req1_ready, 32'd0);
    tick();
    if (!p) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (hold > 0) begin
      if (!p) begin req1_valid = 1'b1; resp1_ready = 1'b1; end
      else begin req0_valid = 1'b1; resp0_ready = 1'b1; end
    end
    #1;
    checkOutput("exec_op0", alu_operand0, a);
    checkOutput("exec_op1", alu_operand1, b);
    checkOutput("exec_ctrl", {28'd0, alu_control}, {28'd0, c});
    checkOutput("exec_busy", busy, 32'd1);
    checkOutput("exec_no_resp", {resp1_valid, resp0_valid}, 32'd0);
    checkOutput("exec_no_ready", {req1_ready, req0_ready}, 32'd0);
    tick();
    for (int k = 0; k <= hold; k++) begin
      checkOutput("resp_own_valid", p ? resp1_valid : resp0_valid, 32'd1);
      checkOutput("resp_other_valid", p ? resp0_valid : resp1_valid, 32'd0);
      checkOutput("resp_id", resp_id, {31'd0, p});
      checkOutput("resp_result", resp_result, er);
      checkOutput("resp_result1", resp_result1, er1);
      checkOutput("resp_flags", {28'd0, resp_flags}, {28'd0, ef});
      checkOutput("resp_no_ready", {req1_ready, req0_ready}, 32'd0);
      if (k == hold) begin
        if (!p) resp0_ready = 1'b1; else resp1_ready = 1'b1;
      end
      tick();
    end
    if (!p) resp0_ready = 1'b0; else resp1_ready = 1'b0;
    #1;
    checkOutput("done_busy", busy, 32'd0);
    checkOutput("done_no_resp", {resp1_valid, resp0_valid}, 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, busy, 32'd0);
    checkOutput({tag, "_ready"}, {req1_ready, req0_ready}, 32'd0);
    checkOutput({tag, "_resp_valid"}, {resp1_valid, resp0_valid}, 32'd0);
    checkOutput({tag, "_result"}, resp_result, 32'd0);
    checkOutput({tag, "_result1"}, resp_result1, 32'd0);
    checkOutput({tag, "_flags_id"}, {27'd0, resp_flags, resp_id}, 32'd0);
    checkOutput({tag, "_alu_op0"}, alu_operand0, 32'd0);
    checkOutput({tag, "_alu_op1"}, alu_operand1, 32'd0);
    checkOutput({tag, "_alu_ctrl"}, {28'd0, alu_control}, 32'd0);
  endtask

  localparam logic [31:0] OPA = 32'h00040600;
  localparam logic [31:0] OPB = 32'hFFFFFFE9;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op0 = '0; req0_op1 = '0; req0_ctrl = '0;
    req1_op0 = '0; req1_op1 = '0; req1_ctrl = '0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkResetState("reset");

    // Single op on port 0, hand-checked result: 0x00040600 + 0xFFFFFFE9
    applyStimulus(1'b0, OPA, OPB, 4'd0, 0);
    checkOutput("single_hand_result", resp_result, 32'h000405E9);
    checkOutput("single_hand_flags", {28'd0, resp_flags}, 32'h2);

    // Control sweep on port 1, one op every 3 cycles
    for (int c = 0; c <= 8; c++) begin
      applyStimulus(1'b1, OPA, OPB, c[3:0], 0);
    end

    // Idle: ALU drive frozen at the last swept op
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("idle_alu_op0", alu_operand0, OPA);
      checkOutput("idle_alu_op1", alu_operand1, OPB);
      checkOutput("idle_alu_ctrl", {28'd0, alu_control}, 32'd8);
      checkOutput("idle_busy", busy, 32'd0);
      checkOutput("idle_ready", {req1_ready, req0_ready}, 32'd0);
    end

    // Backpressure on port 0 while port 1 waits; signed overflow add
    applyStimulus(1'b0, 32'h7FFFFFFF, 32'h00000001, 4'd0, 5);
    checkOutput("bp_hand_result", resp_result, 32'h80000000);
    checkOutput("bp_hand_flags", {28'd0, resp_flags}, 32'hC);
    checkOutput("bp_waiter_granted", req1_ready, 32'd1);
    checkOutput("bp_owner_not_ready", req0_ready, 32'd0);
    req1_valid = 1'b0;
    resp1_ready = 1'b0;

    // Reset during EXEC discards the op
    req1_valid = 1'b1; req1_op0 = 32'h12345678; req1_op1 = 32'h0000000F; req1_ctrl = 4'd4;
    tick();
    req1_valid = 1'b0;
    #1;
    checkOutput("rstmid_in_exec", busy, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkResetState("rstmid");
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rstmid_no_resp", {resp1_valid, resp0_valid}, 32'd0);
    end

    // Tie fairness: both valid continuously, both response readies high
    req0_op0 = 32'd10; req0_op1 = 32'd3; req0_ctrl = 4'd1;
    req1_op0 = 32'd5;  req1_op1 = 32'd5; req1_ctrl = 4'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput("tie_grant", {req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      checkOutput("tie_exec_op0", alu_operand0, (i % 2 == 0) ? 32'd10 : 32'd5);
      checkOutput("tie_exec_ready", {req1_ready, req0_ready}, 32'd0);
      tick();
      checkOutput("tie_resp_id", {31'd0, resp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      checkOutput("tie_resp_valid", {resp1_valid, resp0_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
      checkOutput("tie_resp_result", resp_result, (i % 2 == 0) ? 32'd7 : 32'd0);
      checkOutput("tie_resp_flags", {28'd0, resp_flags}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters (port 0: main execute path, port 1: auxiliary unit such as address/branch compare) using round-robin arbitration. Each operation is a valid/ready transaction. The arbiter registers the operands, drives the ALU for one cycle and captures `result`, `result1` and the four flags. It then holds the response until the owning requester accepts it. At most one operation is in flight.

## Interface
- `WIDTH`, 32, operand/result width (matches `alu`)
- `CTRL_W`, 4, ALU control code width (matches `alu` `control`)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `req0_valid`, `req1_valid`  in  1  requester has an operation
- `req0_ready`, `req1_ready`  out  1  operation accepted this cycle when valid&&ready
- `req0_op0`, `req0_op1`, `req1_op0`, `req1_op1`  in  WIDTH  operands
- `req0_ctrl`, `req1_ctrl`  in  CTRL_W  ALU control code, passed through unmodified
- `resp0_valid`, `resp1_valid`  out  1  response available for that requester
- `resp0_ready`, `resp1_ready`  in  1  requester consumes the response
- `resp_result`, `resp_result1`  out  WIDTH  captured `result` / `result1`
- `resp_flags`  out  4  captured {overflowFlag, signFlag, carryFlag, zFlag}
- `resp_id`  out  1  requester that owns the current response
- `busy`  out  1  high whenever state != IDLE
- `alu_operand0`, `alu_operand1`  out  WIDTH  to `alu` operand0/operand1
- `alu_control`  out  CTRL_W  to `alu` control
- `alu_result`, `alu_result1`  in  WIDTH  from `alu`
- `alu_zFlag`, `alu_carryFlag`, `alu_signFlag`, `alu_overflowFlag`  in  1  from `alu`

## Operation
- FSM states:
  - IDLE: accepts a request. On a handshake, goes to EXEC.
  - EXEC: ALU inputs driven from registers; ALU outputs captured at the end of the cycle. Always goes to RESP after 1 cycle.
  - RESP: `respN_valid` held high. Goes to IDLE when `respN_ready` is high.
- Grant, evaluated in IDLE only:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not in `last_grant`.
  - `last_grant` updates on every accepted request.
- `reqN_ready = (state==IDLE) && grant==N`.
  - `reqN_ready` is combinational from both valids.
  - Requesters must not make valid depend on ready.
- On accept, register `reqN_op0`, `reqN_op1` and `reqN_ctrl` into `alu_operand0`, `alu_operand1` and `alu_control`, and register N into `resp_id`.
- The ALU drive registers hold their value outside EXEC. Nothing else toggles the ALU inputs.
- In EXEC, capture `alu_result`, `alu_result1` and the flags into the `resp_*` registers.
  - Flags are packed into `resp_flags` MSB→LSB: overflow, sign, carry, zero.
- In RESP, only `resp{resp_id}_valid` is high. The other `respN_valid` is 0.
  - Response data is stable while valid is high and not yet accepted.
- The opposing requester's `respN_ready` is ignored.
- A requester may hold valid through its own response. It is re-arbitrated in the next IDLE cycle.
- No reordering and no dropped operations. Each accepted request produces exactly one response to the same port.

## Timing
- Reset values:
  - State IDLE; `last_grant`=1, so port 0 wins the first tie.
  - Outputs zero: all `reqN_ready` gated by state; `respN_valid`, `busy`, `resp_*`, `resp_id`, `alu_operand0/1`, `alu_control` all 0.
- Latency:
  - Accept at edge of cycle N → EXEC in cycle N+1 (ALU inputs valid) → `respN_valid` high in cycle N+2.
  - Best case is 1 operation per 3 cycles, when `respN_ready` is high in the first RESP cycle.
- Back-to-back: the response accept edge returns the FSM to IDLE. The next request can be accepted in the following cycle.
- The ALU is combinational: `alu_*` inputs must settle within the EXEC cycle. There is no multicycle path.
- `rst` asserted in any state returns to IDLE on that edge. Any in-flight operation is discarded with no response, and all outputs return to reset values.
- `reqN_valid` dropping in IDLE without a handshake is legal; no state change.

## Test plan
- Single op: req0 with op0=0x00040600, op1=0xFFFFFFE9, ctrl=4'b0000, accepted at cycle N.
  - `alu_operand0/1/control` show these values in N+1.
  - `resp0_valid`=1 in N+2, with `resp_result`/`resp_result1`/`resp_flags` equal to the `alu` outputs sampled in N+1.
  - `resp1_valid`=0 throughout.
- Control sweep: req1 issues ctrl 4'b0000..4'b1000 with the same operands, `resp1_ready` tied high.
  - 9 responses, one every 3 cycles, each matching the `alu` output for that code.
  - `resp_id`=1 each time.
- Tie fairness: both valid continuously from reset.
  - Grants alternate 0,1,0,1… over 8 operations.
  - Each response `resp_id` matches its grant.
- Backpressure: `resp0_ready` held low for 5 cycles in RESP.
  - `resp0_valid` and all data remain stable.
  - `req1_ready` stays 0.
  - The op completes on the cycle `resp0_ready` rises.
- Reset mid-op: assert `rst` during EXEC.
  - Next cycle: IDLE, `busy`=0, no `respN_valid` ever asserted for that op, all outputs 0.
  - The first post-reset tie is granted to port 0.
- Idle stability: no valids for 20 cycles.
  - `alu_*` outputs unchanged, `busy`=0, both `reqN_ready`=0.
